ram_fifo_ctrl: RTL and testbench

//   FIFO controller that drives the write and read ports of the 16x8 dual-port RAM.

---
 rtl/ram_fifo_ctrl_if.sv | 37 +++
 rtl/ram_fifo_ctrl.sv | 79 +++++++
 tb/tb_ram_fifo_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ram_fifo_ctrl_if.sv
// Purpose: bundles the producer/consumer handshake and the RAM port strobes of the FIFO controller.
// Ports: master = FIFO user plus RAM model (drives push/pop/data and ram_rd_data, sees flags and strobes);
//        slave  = ram_fifo_ctrl (drives flags, pop data/valid and all RAM write/read strobes).
interface ram_fifo_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic              full;
  logic              afull;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              ovf;
  logic              udf;
  logic              ram_wr_enb;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic              ram_rd_enb;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;

  modport master (
    output push, push_data, pop, ram_rd_data,
    input  pop_data, pop_valid, full, afull, empty, count, ovf, udf,
    input  ram_wr_enb, ram_wr_addr, ram_wr_data, ram_rd_enb, ram_rd_addr
  );

  modport slave (
    input  push, push_data, pop, ram_rd_data,
    output pop_data, pop_valid, full, afull, empty, count, ovf, udf,
    output ram_wr_enb, ram_wr_addr, ram_wr_data, ram_rd_enb, ram_rd_addr
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// Purpose: FIFO controller driving a 2**ADDR_W x DATA_W dual-port RAM (read-before-write, registered read).
// Latency: pop_valid/pop_data one cycle after an accepted pop; flags reflect registered pointers.
// Backpressure: push while full and pop while empty are dropped and flagged by one-cycle ovf/udf pulses.
// Ports: clk, rst (async, active-low), bus (slave modport: push/pop handshake, flags, RAM strobes).
module ram_fifo_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int AFULL_THR = 14
) (
  input logic            clk,
  input logic            rst,
  ram_fifo_ctrl_if.slave bus
);

  localparam int PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [PTR_W-1:0]  count_q, count_d;
  logic              pop_valid_q;
  logic              ovf_q;
  logic              udf_q;
  logic              full, empty;
  logic              push_acc, pop_acc;
  logic [DATA_W-1:0] wr_data, rd_data;

  // Extra pointer MSB distinguishes full from empty when the address bits match.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                 (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);

  assign push_acc = bus.push & ~full;
  assign pop_acc  = bus.pop  & ~empty;

  always_comb begin
    wptr_d  = wptr_q + PTR_W'(push_acc);
    rptr_d  = rptr_q + PTR_W'(pop_acc);
    count_d = count_q + PTR_W'(push_acc) - PTR_W'(pop_acc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      pop_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      pop_valid_q <= pop_acc;
      ovf_q       <= bus.push & full;
      udf_q       <= bus.pop & empty;
    end
  end

  // Gate strobes with reset so nothing reaches the RAM while reset is held,
  // even if push is asserted (pointers are equal, so full is low then).
  assign wr_data         = bus.push_data;
  assign rd_data         = bus.ram_rd_data;
  assign bus.ram_wr_enb  = push_acc & rst;
  assign bus.ram_wr_addr = wptr_q[ADDR_W-1:0];
  assign bus.ram_wr_data = wr_data;
  assign bus.ram_rd_enb  = pop_acc & rst;
  assign bus.ram_rd_addr = rptr_q[ADDR_W-1:0];

  // RAM registers read data on the pop edge, so it lines up with pop_valid_q.
  assign bus.pop_data  = rd_data;
  assign bus.pop_valid = pop_valid_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.afull     = (count_q >= PTR_W'(AFULL_THR));
  assign bus.count     = count_q;
  assign bus.ovf       = ovf_q;
  assign bus.udf       = udf_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: a behavioural RAM plus a queue-based FIFO model.
// Inputs are driven on the falling edge and outputs compared 1 ns later.
module tb_ram_fifo_ctrl;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AFULL  = 14;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  ram_fifo_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AFULL_THR(AFULL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dual-port RAM: registered read, read-before-write on same address.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_wr_enb) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
    if (bus.ram_rd_enb) bus.ram_rd_data <= mem[bus.ram_rd_addr];
  end

  // Reference model state
  logic [7:0] q[$];
  int         wr_total, rd_total;
  logic       exp_pv, exp_ovf, exp_udf;
  logic [7:0] exp_pd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    wr_total = 0;
    rd_total = 0;
    exp_pv   = 1'b0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
    exp_pd   = '0;
  endtask

  // One clock: drive, compare everything, advance the model.
  task automatic step(input logic p, input logic [7:0] d, input logic o);
    logic m_full, m_empty, p_acc, o_acc;
    @(negedge clk);
    bus.push      = p;
    bus.push_data = d;
    bus.pop       = o;
    #1;
    m_full  = (q.size() == DEPTH);
    m_empty = (q.size() == 0);
    p_acc   = p && !m_full;
    o_acc   = o && !m_empty;
    check("count",     32'(bus.count), 32'(q.size()));
    check("full",      32'(bus.full),  32'(m_full));
    check("empty",     32'(bus.empty), 32'(m_empty));
    check("afull",     32'(bus.afull), 32'(q.size() >= AFULL));
    check("pop_valid", 32'(bus.pop_valid), 32'(exp_pv));
    if (exp_pv) check("pop_data", 32'(bus.pop_data), 32'(exp_pd));
    check("ovf",       32'(bus.ovf), 32'(exp_ovf));
    check("udf",       32'(bus.udf), 32'(exp_udf));
    check("wr_enb",    32'(bus.ram_wr_enb), 32'(p_acc));
    if (p_acc) begin
      check("wr_addr", 32'(bus.ram_wr_addr), 32'(wr_total % DEPTH));
      check("wr_data", 32'(bus.ram_wr_data), 32'(d));
    end
    check("rd_enb",    32'(bus.ram_rd_enb), 32'(o_acc));
    if (o_acc) check("rd_addr", 32'(bus.ram_rd_addr), 32'(rd_total % DEPTH));
    exp_ovf = p && m_full;
    exp_udf = o && m_empty;
    exp_pv  = o_acc;
    if (o_acc) begin
      exp_pd = q.pop_front();
      rd_total++;
    end
    if (p_acc) begin
      q.push_back(d);
      wr_total++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.push = 1'b0;
    bus.push_data = '0;
    bus.pop  = 1'b0;
    model_reset();
    rst = 1'b0;
    #12;
    check("rst_count", 32'(bus.count), 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_full",  32'(bus.full), 0);
    check("rst_pv",    32'(bus.pop_valid), 0);
    @(negedge clk);
    rst = 1'b1;

    // 1: three pushes then three pops
    step(1, 8'h11, 0); step(1, 8'h22, 0); step(1, 8'h33, 0);
    step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
    step(0, 0, 0); step(0, 0, 0);

    // 2: fill 0x00..0x0F, then one overflow push
    for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0);
    step(1, 8'hEE, 0);
    step(0, 0, 0); step(0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1);
    step(0, 0, 0);

    // 3: underflow, then push+pop on empty
    step(0, 0, 1); step(0, 0, 0);
    step(1, 8'h5C, 1); step(0, 0, 0);
    step(0, 0, 1); step(0, 0, 0);

    // 4: fill, 40 cycles push+pop, then drain across wrap
    for (int i = 0; i < DEPTH; i++) step(1, 8'($urandom), 0);
    for (int i = 0; i < 40; i++) step(1, 8'($urandom), 1);
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 1);

    // 5: count 8, eight push+pop pairs
    for (int i = 0; i < 8; i++) step(1, 8'(8'h80 + i), 0);
    for (int i = 0; i < 8; i++) step(1, 8'(8'h90 + i), 1);
    for (int i = 0; i < 9; i++) step(0, 0, 1);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 45));

    // 6: async reset mid-stream with a pop in flight
    for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0);
    step(1, 8'h77, 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_count", 32'(bus.count), 0);
    check("arst_empty", 32'(bus.empty), 1);
    check("arst_full",  32'(bus.full), 0);
    check("arst_afull", 32'(bus.afull), 0);
    check("arst_pv",    32'(bus.pop_valid), 0);
    check("arst_wr",    32'(bus.ram_wr_enb), 0);
    check("arst_rd",    32'(bus.ram_rd_enb), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    rst = 1'b1;
    step(1, 8'hA5, 0); step(0, 0, 1); step(0, 0, 0); step(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
